// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz VGA timing constants shared by the sync generator and the pixel colour stage.
package vga_timing_pkg;

    localparam int CNT_W       = 10;
    localparam int PIX_CLK_DIV = 4;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Both sync pulses are active-low for this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    // True when pos lies in [lo, lo+len); 11-bit so a window ending at 1024 still compares correctly.
    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int len);
        logic [CNT_W:0] w_pos;
        w_pos = {1'b0, pos};
        return (w_pos >= (CNT_W+1)'(lo)) && (w_pos < (CNT_W+1)'(lo + len));
    endfunction

endpackage

// File: rtl/vga_sync_gen_clk_en_div.sv
// Divide-by-DIV clock enable: tick is a registered one-clk pulse, high while the divider sits at DIV-1.
module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_div;
    logic [W-1:0] w_div_next;
    logic         r_tick;

    always_comb begin
        w_div_next = (r_div == LAST) ? '0 : r_div + W'(1);
    end

    // tick is registered from the next divider value so it is low during reset, even when DIV is 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel enable, x/y counters and registered display/sync/start flags.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = PIX_CLK_DIV,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             display,
    output logic             Hsync,
    output logic             Vsync,
    output logic             pixelTick,
    output logic             lineStart,
    output logic             frameStart
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);

    logic             w_tick;
    logic [CNT_W-1:0] r_x, r_y;
    logic [CNT_W-1:0] w_x_next, w_y_next;
    logic             r_display, r_hsync, r_vsync;
    logic             r_line_start, r_frame_start;

    clk_en_div #(
        .DIV (CLK_DIV)
    ) u_pix_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Counters sit at the last position in reset so the first tick lands on (0,0).
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (r_x == H_LAST) begin
                w_x_next = '0;
                w_y_next = (r_y == V_LAST) ? '0 : r_y + CNT_W'(1);
            end else begin
                w_x_next = r_x + CNT_W'(1);
            end
        end
    end

    // Decodes use the next counter values so flags and counters change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_display     <= 1'b0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_display     <= in_window(w_x_next, 0, H_VISIBLE) && in_window(w_y_next, 0, V_VISIBLE);
            r_hsync       <= in_window(w_x_next, H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= in_window(w_y_next, V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_line_start  <= (w_x_next == '0);
            r_frame_start <= (w_x_next == '0) && (w_y_next == '0);
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign display    = r_display;
    assign Hsync      = r_hsync;
    assign Vsync      = r_vsync;
    assign pixelTick  = w_tick;
    assign lineStart  = r_line_start;
    assign frameStart = r_frame_start;

endmodule
